// File: rtl/tagged_rr_merger_if.sv
// tagged_i: tagged stream bus with payload, tag, byte keep, last and valid/ready handshake.
interface tagged_i #(
    parameter type data_t     = logic [31:0],
    parameter int  TAG_WIDTH  = 4,
    parameter int  KEEP_WIDTH = ($bits(data_t) + 7) / 8
);
    data_t                 data;
    logic [TAG_WIDTH-1:0]  tag;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport m (output data, tag, keep, last, valid, input ready);
    modport s (input data, tag, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_rr_merger.sv
// tagged_rr_merger: round-robin N:1 merger of tagged streams into one registered output stage.
// Define TAGGED_RR_MERGER_PKT_LOCK_EN to hold the grant from a packet's first beat to its 'last';
// without it the arbiter re-arbitrates on every beat and packets from different inputs interleave.
module tagged_rr_merger #(
    parameter int NUM_STREAMS = 2
) (
    input  logic clk,
    input  logic rst_n,
    tagged_i.s   in_i [NUM_STREAMS],
    tagged_i.m   out_o
);
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int DW = $bits(out_o.data);
    localparam int TW = $bits(out_o.tag);
    localparam int KW = $bits(out_o.keep);
`ifdef TAGGED_RR_MERGER_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic [NUM_STREAMS-1:0] valid_in, last_in;
    logic [DW-1:0]          data_in [NUM_STREAMS];
    logic [TW-1:0]          tag_in  [NUM_STREAMS];
    logic [KW-1:0]          keep_in [NUM_STREAMS];

    logic [IW-1:0] grant_q, grant_d, winner, idx;
    logic          locked_q, locked_d, valid_q, valid_d, last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          found, load, hs;

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_in
        assign valid_in[g]    = in_i[g].valid;
        assign last_in[g]     = in_i[g].last;
        assign data_in[g]     = in_i[g].data;
        assign tag_in[g]      = in_i[g].tag;
        assign keep_in[g]     = in_i[g].keep;
        assign in_i[g].ready  = hs && (winner == IW'(g));
    end

    assign load = !valid_q || out_o.ready;
    assign hs   = load && found && rst_n;

    // Pick the first requester after the last grant (last grant scanned last), or stay on the locked input
    always_comb begin
        winner = grant_q;
        found  = 1'b0;
        idx    = grant_q;
        if (locked_q) begin
            found = valid_in[grant_q];
        end else begin
            for (int k = NUM_STREAMS; k >= 1; k--) begin
                idx = IW'((int'(grant_q) + k) % NUM_STREAMS);
                if (valid_in[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    // Load the winning beat into the output stage, or drain the stage once its beat is consumed
    always_comb begin
        grant_d  = grant_q;
        locked_d = locked_q;
        valid_d  = valid_q;
        data_d   = data_q;
        tag_d    = tag_q;
        keep_d   = keep_q;
        last_d   = last_q;
        if (hs) begin
            grant_d  = winner;
            locked_d = LOCK_EN && !last_in[winner];
            valid_d  = 1'b1;
            data_d   = data_in[winner];
            tag_d    = tag_in[winner];
            keep_d   = keep_in[winner];
            last_d   = last_in[winner];
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    // Control state; reset points the grant at the last input so input 0 is scanned first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            grant_q  <= IW'(NUM_STREAMS - 1);
        end else begin
            valid_q  <= valid_d;
            locked_q <= locked_d;
            grant_q  <= grant_d;
        end
    end

    // Payload registers only matter while valid_q is set, so they carry no reset
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
        keep_q <= keep_d;
        last_q <= last_d;
    end

    assign out_o.valid = valid_q;
    assign out_o.data  = data_q;
    assign out_o.tag   = tag_q;
    assign out_o.keep  = keep_q;
    assign out_o.last  = last_q;
endmodule

// File: tb/tb_tagged_rr_merger.sv
// tb_tagged_rr_merger: randomized and directed check of tagged_rr_merger against a behavioural model.
module tb_tagged_rr_merger;
    localparam int N = 4;
`ifdef TAGGED_RR_MERGER_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic o_rdy = 1'b1;
    always #5 clk = ~clk;

    tagged_i #(.data_t(logic [15:0]), .TAG_WIDTH(4)) in_if [N] ();
    tagged_i #(.data_t(logic [15:0]), .TAG_WIDTH(4)) out_if ();

    logic [15:0]  d   [N];
    logic [3:0]   tg  [N];
    logic [1:0]   kp  [N];
    logic [N-1:0] v = '0, l = '0, rdy;

    for (genvar g = 0; g < N; g++) begin : g_src
        assign in_if[g].data  = d[g];
        assign in_if[g].tag   = tg[g];
        assign in_if[g].keep  = kp[g];
        assign in_if[g].last  = l[g];
        assign in_if[g].valid = v[g];
        assign rdy[g]         = in_if[g].ready;
    end
    assign out_if.ready = o_rdy;

    tagged_rr_merger #(.NUM_STREAMS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (in_if),
        .out_o (out_if)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_grant = N - 1;   // input granted most recently
    int           m_lock  = -1;      // input owning an open packet, -1 if none
    bit           m_valid = 1'b0;
    logic [22:0]  m_beat  = '0;      // {data, tag, keep, last} held on the output
    bit           started = 1'b0;
    bit           load = 1'b0, hs = 1'b0;
    int           win = -1;
    logic [N-1:0] exp_acc = '0, acc = '0;
    int           stamp = 0;
    int           log_id[$];
    int           log_stamp[$];

    // Compare process: predict this cycle's transfer and check every visible output
    always @(negedge clk) begin
        stamp++;
        load = !m_valid || o_rdy;
        win  = -1;
        if (m_lock >= 0) begin
            if (v[m_lock]) win = m_lock;
        end else begin
            for (int k = 1; k <= N; k++)
                if (win < 0 && v[(m_grant + k) % N]) win = (m_grant + k) % N;
        end
        hs      = rst_n && load && (win >= 0);
        exp_acc = '0;
        if (hs) exp_acc[win] = 1'b1;
        if (started) begin
            chk("ready", 32'(rdy & v), 32'(exp_acc));
            chk("out_valid", 32'(out_if.valid), 32'(m_valid));
            if (m_valid)
                chk("out_beat", 32'({out_if.data, out_if.tag, out_if.keep, out_if.last}), 32'(m_beat));
            if (out_if.valid && o_rdy) begin
                log_id.push_back(int'(out_if.data[15:12]));
                log_stamp.push_back(stamp);
            end
        end
    end

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_lock  = -1;
            m_grant = N - 1;
        end else if (hs) begin
            m_valid = 1'b1;
            m_beat  = {d[win], tg[win], kp[win], l[win]};
            m_grant = win;
            m_lock  = (LOCK && !l[win]) ? win : -1;
        end else if (load) begin
            m_valid = 1'b0;
        end
        acc = exp_acc;
    end

    // ---------------- sources ----------------
    int seq [N], rem [N], plen [N], pkts [N], pct [N], gap_after [N], hold [N], bip [N];
    bit en [N];

    function automatic int new_len(input int i);
        return (plen[i] > 0) ? plen[i] : int'($urandom_range(4, 1));
    endfunction

    task automatic src_init(input int i, input bit e, input int len, input int np, input int p, input int gap);
        en[i] = e; plen[i] = len; pkts[i] = np; pct[i] = p; gap_after[i] = gap;
        hold[i] = 0; bip[i] = 0; rem[i] = new_len(i); v[i] = 1'b0;
        d[i] = {4'(i), 12'(seq[i])}; tg[i] = 4'($urandom); kp[i] = 2'(seq[i]); l[i] = (rem[i] == 1);
    endtask

    task automatic src_step();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                seq[i]++; rem[i]--; bip[i]++;
                if (gap_after[i] != 0 && bip[i] == gap_after[i]) hold[i] = 3;
                if (rem[i] == 0) begin
                    bip[i] = 0;
                    if (pkts[i] > 0) pkts[i]--;
                    rem[i] = new_len(i);
                end
                tg[i] = 4'($urandom);
            end
            if (hold[i] > 0) begin
                hold[i]--;
                v[i] = 1'b0;
            end else if (!v[i] || acc[i]) begin
                v[i] = en[i] && pkts[i] != 0 && (int'($urandom_range(99)) < pct[i]);
            end
            d[i]  = {4'(i), 12'(seq[i])};
            kp[i] = 2'(seq[i]);
            l[i]  = (rem[i] == 1);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            src_step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] ids(input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++)
            r = (r << 4) | ((k < log_id.size()) ? 32'(log_id[k]) : 32'hF);
        return r;
    endfunction

    task automatic clear_log();
        log_id.delete();
        log_stamp.delete();
    endtask

    logic [22:0] held;
    int          n0;

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i] = i * 256;
            src_init(i, 1'b1, 1, -1, 100, 0);
        end
        // Reset with every input requesting: nothing accepted, output idle
        rst_n = 1'b0;
        repeat (3) begin
            cyc(1);
            chk("t1_ready", 32'(rdy), 32'h0);
            chk("t1_valid", 32'(out_if.valid), 32'h0);
        end
        rst_n = 1'b1;
        // All inputs single-beat: strict rotation starting at input 0
        clear_log();
        cyc(10);
        chk("t2_order", ids(8), 32'h01230123);

        // Input 0 sends one 4-beat packet while input 1 streams single beats
        src_init(0, 1'b1, 4, 1, 100, 0);
        src_init(1, 1'b1, 1, -1, 100, 0);
        src_init(2, 1'b0, 1, -1, 100, 0);
        src_init(3, 1'b0, 1, -1, 100, 0);
        do_reset();
        clear_log();
        cyc(12);
        chk("t3_order", ids(6), LOCK ? 32'h000011 : 32'h010101);

        // Back-pressure: output frozen, no input accepted, then no bubble on release
        for (int i = 0; i < N; i++) src_init(i, 1'b1, 0, -1, 100, 0);
        do_reset();
        cyc(5);
        o_rdy = 1'b0;
        cyc(1);
        held = {out_if.data, out_if.tag, out_if.keep, out_if.last};
        repeat (5) begin
            cyc(1);
            chk("t5_hold", 32'({out_if.data, out_if.tag, out_if.keep, out_if.last}), 32'(held));
            chk("t5_ready", 32'(rdy & v), 32'h0);
            chk("t5_valid", 32'(out_if.valid), 32'h1);
        end
        n0 = log_id.size();
        o_rdy = 1'b1;
        cyc(4);
        chk("t5_nobubble", 32'(log_id.size() - n0), 32'd4);

        // Locked input pauses 3 cycles after its second beat while input 1 keeps requesting
        src_init(0, 1'b1, 4, 1, 100, 2);
        src_init(1, 1'b1, 1, -1, 100, 0);
        src_init(2, 1'b0, 1, -1, 100, 0);
        src_init(3, 1'b0, 1, -1, 100, 0);
        do_reset();
        clear_log();
        cyc(16);
        if (LOCK) begin
            chk("t6_order", ids(6), 32'h000011);
            chk("t6_gap", 32'(log_stamp[2] - log_stamp[1]), 32'd4);
        end else begin
            chk("t6_order", ids(7), 32'h0101110);
        end

        // Random traffic, random back-pressure and a reset in the middle of traffic
        for (int i = 0; i < N; i++) src_init(i, 1'b1, 0, -1, 60, 0);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            o_rdy = ($urandom_range(3) != 0);
            if (c == 1500) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        o_rdy = 1'b1;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
